fp32_adder_arbiter: RTL and testbench

//  Shares one combinational FP32Adder among NREQ requesters (matrix-multiplier accumulate lanes).

---
 rtl/fp32_arb_pkg.sv | 35 +++
 rtl/fp32_adder.sv | 107 ++++++++++
 rtl/fp32_rr_arbiter.sv | 32 +++
 rtl/fp32_adder_arbiter.sv | 105 ++++++++++
 tb/tb_fp32_adder_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_arb_pkg.sv
// Shared FP32 field layout, response-flag bit positions and the flag derivation helper.
// The helper is only referenced when FP32_ARB_FLAGS_EN is defined.
package fp32_arb_pkg;

    localparam int unsigned FP32_W        = 32;
    localparam int unsigned EXP_MSB       = 30;
    localparam int unsigned EXP_LSB       = 23;
    localparam int unsigned FRAC_W        = 23;
    localparam logic [7:0]  EXP_ALL1      = 8'hFF;
    localparam int unsigned FLAGS_W       = 3;
    localparam int unsigned FLAG_INVALID  = 0;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_ZERO     = 2;

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic [FLAGS_W-1:0] fp32_flags(
        input logic [FP32_W-1:0] a,
        input logic [FP32_W-1:0] b,
        input logic [FP32_W-1:0] s
    );
        logic [FLAGS_W-1:0] f;
        f = '0;
        f[FLAG_INVALID]  = (s[EXP_MSB:EXP_LSB] == EXP_ALL1) && (s[FRAC_W-1:0] != '0);
        f[FLAG_OVERFLOW] = (s[EXP_MSB:EXP_LSB] == EXP_ALL1) && (s[FRAC_W-1:0] == '0) &&
                           (a[EXP_MSB:EXP_LSB] != EXP_ALL1) && (b[EXP_MSB:EXP_LSB] != EXP_ALL1);
        f[FLAG_ZERO]     = (s[EXP_MSB:0] == '0);
        return f;
    endfunction

endpackage

// File: rtl/fp32_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even, subnormals supported.
module fp32_adder
    import fp32_arb_pkg::*;
(
    input  logic [FP32_W-1:0] i_a,
    input  logic [FP32_W-1:0] i_b,
    output logic [FP32_W-1:0] o_sum
);

    fp32_t       w_a, w_b, w_x, w_y;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [7:0]  w_ex, w_ey, w_diff;
    logic [26:0] w_mx, w_my, w_my_sh;
    logic        w_sticky;
    logic [27:0] w_raw;
    logic [4:0]  w_lz;
    logic [9:0]  w_ex_m1, w_shift, w_exp, w_exp_f;
    logic [26:0] w_norm;
    logic        w_inc;
    logic [24:0] w_rnd;
    logic [23:0] w_mant;

    assign w_a     = i_a;
    assign w_b     = i_b;
    assign w_a_nan = (w_a.exp == EXP_ALL1) && (w_a.frac != '0);
    assign w_b_nan = (w_b.exp == EXP_ALL1) && (w_b.frac != '0);
    assign w_a_inf = (w_a.exp == EXP_ALL1) && (w_a.frac == '0);
    assign w_b_inf = (w_b.exp == EXP_ALL1) && (w_b.frac == '0);

    // x is the larger magnitude so the aligned difference is never negative
    assign w_x  = (i_b[EXP_MSB:0] > i_a[EXP_MSB:0]) ? w_b : w_a;
    assign w_y  = (i_b[EXP_MSB:0] > i_a[EXP_MSB:0]) ? w_a : w_b;
    assign w_ex = (w_x.exp == 8'd0) ? 8'd1 : w_x.exp;
    assign w_ey = (w_y.exp == 8'd0) ? 8'd1 : w_y.exp;
    assign w_mx = {(w_x.exp != 8'd0), w_x.frac, 3'b000};
    assign w_my = {(w_y.exp != 8'd0), w_y.frac, 3'b000};
    assign w_diff = w_ex - w_ey;

    always_comb begin
        w_my_sh  = '0;
        w_sticky = 1'b0;
        if (w_diff >= 8'd27) begin
            w_sticky = |w_my;
        end else begin
            w_my_sh  = w_my >> w_diff;
            w_sticky = |(w_my & ((27'd1 << w_diff) - 27'd1));
        end
        w_my_sh[0] = w_my_sh[0] | w_sticky;
    end

    assign w_raw = (w_x.sign == w_y.sign) ? ({1'b0, w_mx} + {1'b0, w_my_sh})
                                          : ({1'b0, w_mx} - {1'b0, w_my_sh});

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_raw[i]) w_lz = 5'(26 - i);
        end
    end

    // Left shift stops at exponent 1 so tiny results land in the subnormal range
    always_comb begin
        w_ex_m1 = {2'b00, w_ex} - 10'd1;
        w_shift = '0;
        if (w_raw[27]) begin
            w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_exp  = {2'b00, w_ex} + 10'd1;
        end else begin
            w_shift = ({5'd0, w_lz} > w_ex_m1) ? w_ex_m1 : {5'd0, w_lz};
            w_norm  = w_raw[26:0] << w_shift;
            w_exp   = {2'b00, w_ex} - w_shift;
        end
    end

    always_comb begin
        w_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_inc};
        if (w_rnd[24]) begin
            w_mant  = w_rnd[24:1];
            w_exp_f = w_exp + 10'd1;
        end else begin
            w_mant  = w_rnd[23:0];
            w_exp_f = w_exp;
        end
    end

    always_comb begin
        if (w_a_nan) begin
            o_sum = i_a | 32'h0040_0000;
        end else if (w_b_nan) begin
            o_sum = i_b | 32'h0040_0000;
        end else if (w_a_inf && w_b_inf && (w_a.sign != w_b.sign)) begin
            o_sum = 32'h7FC0_0000;
        end else if (w_a_inf) begin
            o_sum = i_a;
        end else if (w_b_inf) begin
            o_sum = i_b;
        end else if (w_raw == '0) begin
            o_sum = {w_a.sign & w_b.sign, 31'd0};
        end else if (w_exp_f >= 10'd255) begin
            o_sum = {w_x.sign, EXP_ALL1, 23'd0};
        end else begin
            o_sum = {w_x.sign, (w_mant[23] ? w_exp_f[7:0] : 8'd0), w_mant[22:0]};
        end
    end

endmodule

// File: rtl/fp32_rr_arbiter.sv
// Round-robin arbiter: first set request scanning upward from the pointer, wrapping to 0.
module fp32_rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_valid
);

    logic [IDW-1:0] w_cand;

    // Candidate index wraps with a true modulo so non-power-of-two NREQ works
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % int'(NREQ));
            if (i_en && !o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/fp32_adder_arbiter.sv
// Shares one FP32 adder among NREQ requesters with round-robin grant and a registered result.
// Define FP32_ARB_FLAGS_EN to add the registered rsp_flags {zero, overflow, invalid} port.
module fp32_adder_arbiter
    import fp32_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*FP32_W-1:0]   req_a,
    input  logic [NREQ*FP32_W-1:0]   req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [FP32_W-1:0]        rsp_sum,
    output logic [IDW-1:0]           rsp_id
`ifdef FP32_ARB_FLAGS_EN
    ,
    output logic [FLAGS_W-1:0]       rsp_flags
`endif
);

    logic              r_valid;
    logic [FP32_W-1:0] r_sum;
    logic [IDW-1:0]    r_id;
    logic [IDW-1:0]    r_ptr;

    logic              w_slot_free;
    logic [NREQ-1:0]   w_gnt;
    logic [IDW-1:0]    w_idx;
    logic              w_gnt_valid;
    logic [FP32_W-1:0] w_a, w_b, w_sum;
    logic [IDW-1:0]    w_ptr_nxt;

    assign w_slot_free = !r_valid || rsp_ready;

    fp32_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_slot_free),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_gnt_valid)
    );

    // One-hot AND-OR operand mux
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a = req_a[i*FP32_W +: FP32_W];
                w_b = req_b[i*FP32_W +: FP32_W];
            end
        end
    end

    fp32_adder u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum)
    );

    assign w_ptr_nxt = IDW'((int'(w_idx) + 1) % int'(NREQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_gnt_valid) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_id    <= w_idx;
            r_ptr   <= w_ptr_nxt;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef FP32_ARB_FLAGS_EN
    logic [FLAGS_W-1:0] r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_gnt_valid) begin
            r_flags <= fp32_flags(w_a, w_b, w_sum);
        end
    end

    assign rsp_flags = r_flags;
`endif

    assign req_ready = w_gnt;
    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;

endmodule

// File: tb/tb_fp32_adder_arbiter.sv
// Directed bench for fp32_adder_arbiter with a cycle-level reference model of arbitration.
module tb_fp32_adder_arbiter;

    localparam int NREQ = 4;
    localparam int NV   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [31:0]        rsp_sum;
    logic [1:0]         rsp_id;
`ifdef FP32_ARB_FLAGS_EN
    logic [2:0]         rsp_flags;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed operand table; entry 4 is any NaN
    logic [31:0] va [NV] = '{32'h40400000, 32'h40400000, 32'h00000000, 32'h7f7fffff,
                             32'h7f800001, 32'h3f800000, 32'h40000000, 32'hc0000000};
    logic [31:0] vb [NV] = '{32'h40700000, 32'hc0700000, 32'h40700000, 32'h7f7fffff,
                             32'h40700000, 32'h3f800000, 32'h3f800000, 32'h40000000};
    logic [31:0] vs [NV] = '{32'h40d80000, 32'hbf400000, 32'h40700000, 32'h7f800000,
                             32'h7fc00001, 32'h40000000, 32'h40400000, 32'h00000000};

    fp32_adder_arbiter #(
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef FP32_ARB_FLAGS_EN
        ,
        .rsp_flags (rsp_flags)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != 0);
    endfunction

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        for (int v = 0; v < NV; v++) if (va[v] == a && vb[v] == b) return vs[v];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [2:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] s);
        logic inf_s, fin_ops;
        inf_s   = (s[30:0] == 31'h7f800000);
        fin_ops = (a[30:23] != 8'hff) && (b[30:23] != 8'hff);
        return {s[30:0] == 0, inf_s && fin_ops, is_nan(s)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_sum(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (is_nan(exp)) begin
            checks++;
            if (!is_nan(act)) begin
                errors++;
                $display("FAIL %s: got %h, expected a NaN (t=%0t)", name, act, $time);
            end
        end else begin
            chk(name, act, exp);
        end
    endtask

    // Reference model: compares at each falling edge, then advances to the next rising edge
    logic        m_valid = 1'b0;
    logic [31:0] m_sum   = '0;
    int          m_id    = 0;
    int          m_ptr   = 0;
    logic [2:0]  m_flags = '0;

    initial forever begin
        logic [NREQ-1:0] exp_ready;
        logic [31:0]     ga, gb;
        int              g;
        @(negedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_sum = '0; m_id = 0; m_ptr = 0; m_flags = '0;
        end
        exp_ready = '0;
        g = -1;
        if (rst_n && (!m_valid || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk_sum("rsp_sum", rsp_sum, m_sum);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef FP32_ARB_FLAGS_EN
        chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
`endif
        if (rst_n) begin
            if (g >= 0) begin
                ga      = req_a[32*g +: 32];
                gb      = req_b[32*g +: 32];
                m_valid = 1'b1;
                m_sum   = model_sum(ga, gb);
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
                m_flags = model_flags(ga, gb, m_sum);
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int v);
        req_a[32*r +: 32] = va[v];
        req_b[32*r +: 32] = vb[v];
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] t3_sum [5] = '{32'h40000000, 32'h40400000, 32'h00000000,
                                32'h40d80000, 32'h40000000};

    initial begin
        do_reset();
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_sum", rsp_sum, 32'd0);

        // Single transfers and id/pointer progression
        set_req(0, 0); req_valid = 4'b0001;
        tick(); req_valid = '0; #1;
        chk("t1 sum", rsp_sum, 32'h40d80000);
        chk("t1 id", 32'(rsp_id), 32'd0);
        set_req(2, 1); req_valid = 4'b0100;
        tick(); req_valid = '0; #1;
        chk("t2 sum", rsp_sum, 32'hbf400000);
        chk("t2 id", 32'(rsp_id), 32'd2);
        set_req(1, 2); req_valid = 4'b0010;
        tick(); req_valid = '0; #1;
        chk("t2 zero+b", rsp_sum, 32'h40700000);
        chk("t2b id", 32'(rsp_id), 32'd1);

        // All requesters valid from reset: full round-robin rotation
        do_reset();
        set_req(0, 5); set_req(1, 6); set_req(2, 7); set_req(3, 0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk("t3 id", 32'(rsp_id), 32'(k % 4));
            chk("t3 sum", rsp_sum, t3_sum[k]);
        end
        req_valid = '0;

        // Back-pressure holds the result and blocks new grants
        rsp_ready = 1'b0;
        set_req(1, 6); req_valid = 4'b0010;
        repeat (3) begin
            tick();
            chk("t4 ready held", 32'(req_ready), 32'd0);
            chk("t4 sum held", rsp_sum, 32'h40000000);
        end
        rsp_ready = 1'b1; #1;
        chk("t4 ready release", 32'(req_ready), 32'b0010);
        tick(); req_valid = '0; #1;
        chk("t4 sum", rsp_sum, 32'h40400000);
        chk("t4 id", 32'(rsp_id), 32'd1);

        // Overflow to infinity and NaN pass-through
        set_req(3, 3); req_valid = 4'b1000;
        tick(); req_valid = '0; #1;
        chk("t5 inf", rsp_sum, 32'h7f800000);
`ifdef FP32_ARB_FLAGS_EN
        chk("t5 flags ovf", 32'(rsp_flags), 32'b010);
`endif
        set_req(0, 4); req_valid = 4'b0001;
        tick(); req_valid = '0; #1;
        chk_sum("t5 nan", rsp_sum, 32'h7fc00001);
`ifdef FP32_ARB_FLAGS_EN
        chk("t5 flags nan", 32'(rsp_flags), 32'b001);
`endif

        // Reset while holding a result with ptr=2, then re-arbitrate from 0
        set_req(1, 5); req_valid = 4'b0010;
        tick(); req_valid = '0; rsp_ready = 1'b0;
        tick();
        rst_n = 1'b0; #1;
        chk("t6 reset drops", 32'(rsp_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        set_req(1, 5); set_req(3, 6); req_valid = 4'b1010;
        tick(); #1;
        chk("t6 first id", 32'(rsp_id), 32'd1);
        tick(); #1;
        chk("t6 second id", 32'(rsp_id), 32'd3);
        req_valid = '0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
